dff_response_checker: RTL and testbench
=======================================

// Module: dff_response_checker
// PURPOSE
//  Self-checking response monitor for the D flip-flop with clear: the receiving end of the stimulus path.
//  Observes the stimulus driven into a DFF (data + clear) and the DFF's output each cycle.
//  Runs a golden DFF model, flags every mismatch, counts errors and checked cycles, and reports pass/fail.
//  Sits beside the DFF under test in self-checking simulations and on-board test harnesses.
// PARAMETERS
//  ERR_W        8   width of ERR_COUNT; the counter saturates at 2**ERR_W-1
//  CHK_W        16  width of CHECKED_COUNT; the counter saturates at 2**CHK_W-1
//  SETTLE       2   cycles skipped after entering SETTLE before comparison starts (minimum 1)
//  STOP_ON_FAIL 0   1: the first mismatch moves the FSM to HALT; 0: checking continues
// PORTS
//  CLOCK          in   1      single clock; every register updates on the rising edge
//  CLEAR          in   1      synchronous, active-high reset of the checker itself
//  ENABLE         in   1      level; 1 = run the checker, 0 = return to IDLE
//  STIM_D         in   1      data value driven to the DUT's INPUT
//  STIM_CLR       in   1      clear value driven to the DUT's CLEAR (active-high, asynchronous at the DUT)
//  DUT_Q          in   1      DUT OUTPUT, sampled just before the rising edge
//  EXPECT         out  1      combinational expected DUT output for the current cycle
//  MISMATCH       out  1      registered one-cycle pulse per failed compare
//  ERR_COUNT      out  ERR_W  number of mismatches
//  CHECKED_COUNT  out  CHK_W  number of compares performed
//  STATE          out  2      FSM state: 0 IDLE, 1 SETTLE, 2 CHECK, 3 HALT
//  PASS           out  1      1 when STATE==CHECK or HALT and ERR_COUNT==0
// BEHAVIOUR
//  Reset (CLEAR=1 at an edge): model_q=0, STATE=IDLE, MISMATCH=0, both counters=0, settle counter=0.
//    CLEAR overrides every other input.
//  Golden model: the model updates every cycle in every non-reset state.
//    On each edge: model_q <= STIM_CLR ? 0 : STIM_D.
//    EXPECT = STIM_CLR ? 0 : model_q. This mirrors the DUT's asynchronous clear forcing Q=0 within the cycle.
//  FSM:
//    IDLE -> SETTLE when ENABLE=1; the settle counter loads SETTLE-1.
//    SETTLE decrements the counter each cycle and moves to CHECK when it reaches 0. No compares occur in SETTLE.
//    CHECK compares each cycle: DUT_Q != EXPECT is a mismatch.
//      STOP_ON_FAIL=1 and a mismatch -> HALT.
//      ERR_COUNT reaching saturation -> HALT.
//    HALT holds the counters, MISMATCH=0, and performs no compares.
//    ENABLE=0 moves any non-reset state to IDLE at the next edge. The counters keep their values.
//      Only CLEAR zeroes the counters.
//  Compare latency: a compare of cycle N's DUT_Q/EXPECT produces MISMATCH and counter updates at edge N+1.
//  Counters: a compare in CHECK increments CHECKED_COUNT. A mismatch also increments ERR_COUNT.
//    Both counters saturate and never wrap.
//  Simultaneous events: ENABLE falls in the same cycle as a mismatch -> the mismatch is still counted and pulsed,
//    and the FSM goes to IDLE.
//  A CLEAR during CHECK discards the in-flight compare.
//  An X or Z on DUT_Q counts as a mismatch (use a !== compare).
//  PASS is combinational from STATE and ERR_COUNT. PASS=0 in IDLE/SETTLE.
// STRUCTURE
//  Package dff_chk_pkg: state enum localparams (IDLE/SETTLE/CHECK/HALT = 2'd0..3) and the STATE width.
//  Sub-module dff_golden_model: a single model_q register and the EXPECT mux. The top module holds the FSM,
//    the settle counter and the saturating counters.
// TESTING
//  1. CLEAR=1 for 2 cycles -> STATE=0, ERR_COUNT=0, CHECKED_COUNT=0, MISMATCH=0, PASS=0.
//  2. ENABLE=1, SETTLE=2, DUT_Q tied to a correct DFF, STIM_D toggling every 2 cycles for 20 cycles
//     -> STATE=2 after 2 cycles, CHECKED_COUNT=18, ERR_COUNT=0, PASS=1.
//  3. STIM_CLR=1 for 4 cycles with STIM_D=1 and a correct DUT -> EXPECT=0, DUT_Q=0, no mismatch.
//     Release STIM_CLR -> EXPECT=1 one cycle later.
//  4. Force DUT_Q inverted for 3 cycles in CHECK -> three MISMATCH pulses, each 1 cycle after its bad sample;
//     ERR_COUNT=3, PASS=0.
//  5. STOP_ON_FAIL=1 with a single injected error -> STATE=3 on the next edge, ERR_COUNT=1, CHECKED_COUNT frozen.
//  6. ERR_W=2 with a permanently wrong DUT -> ERR_COUNT stops at 3, STATE=3.
//     Drop ENABLE -> STATE=0, counts retained. CLEAR -> counts zero.

Source files
------------

// File: rtl/dff_chk_pkg.sv
// Shared definitions for the DFF response checker: FSM state encoding and width.
package dff_chk_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_HALT   = 2'd3
  } chk_state_t;

endpackage

// File: rtl/dff_golden_model.sv
// Reference D flip-flop with clear; produces the value a correct DUT should show this cycle.
module dff_golden_model (
  input  logic clock,
  input  logic clear,
  input  logic stim_d,
  input  logic stim_clr,
  output logic expected
);

  logic modelQ;

  // The model tracks the stimulus in every state so it is already in sync when checking begins.
  always_ff @(posedge clock) begin
    if (clear) begin
      modelQ <= 1'b0;
    end else begin
      modelQ <= stim_clr ? 1'b0 : stim_d;
    end
  end

  // The DUT clear is asynchronous, so an active clear forces the expected output low immediately.
  assign expected = stim_clr ? 1'b0 : modelQ;

endmodule

// File: rtl/dff_response_checker.sv
// Response monitor for a DFF with clear: compares the DUT output against a golden model and keeps score.
module dff_response_checker
  import dff_chk_pkg::*;
#(
  parameter int ERR_W        = 8,
  parameter int CHK_W        = 16,
  parameter int SETTLE       = 2,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               enable,
  input  logic               stim_d,
  input  logic               stim_clr,
  input  logic               dut_q,
  output logic               expected,
  output logic               mismatch,
  output logic [ERR_W-1:0]   err_count,
  output logic [CHK_W-1:0]   checked_count,
  output logic [STATE_W-1:0] state,
  output logic               pass
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'((2 ** ERR_W) - 2);
  localparam logic [CHK_W-1:0] CHK_MAX  = '1;

  chk_state_t curState;
  chk_state_t nextState;
  logic [SET_W-1:0] settleCount;
  logic doCompare;
  logic miss;
  logic errFills;

  dff_golden_model u_model (
    .clock    (clock),
    .clear    (clear),
    .stim_d   (stim_d),
    .stim_clr (stim_clr),
    .expected (expected)
  );

  assign doCompare = (curState == ST_CHECK);
  assign miss      = doCompare && (dut_q !== expected);
  assign errFills  = miss && (err_count == ERR_LAST);

  always_ff @(posedge clock) begin
    if (clear) begin
      curState <= ST_IDLE;
    end else begin
      curState <= nextState;
    end
  end

  // Dropping enable always wins, so a mismatch in the same cycle is scored but the FSM still idles.
  always_comb begin
    nextState = curState;
    case (curState)
      ST_IDLE:   if (enable) nextState = ST_SETTLE;
      ST_SETTLE: if (settleCount == '0) nextState = ST_CHECK;
      ST_CHECK:  if (((STOP_ON_FAIL != 0) && miss) || errFills || (err_count == ERR_MAX))
                   nextState = ST_HALT;
      ST_HALT:   nextState = ST_HALT;
      default:   nextState = ST_IDLE;
    endcase
    if (!enable) nextState = ST_IDLE;
  end

  always_comb begin
    state = curState;
    pass  = ((curState == ST_CHECK) || (curState == ST_HALT)) && (err_count == '0);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      settleCount <= '0;
    end else if ((curState == ST_IDLE) && enable) begin
      settleCount <= SET_LOAD;
    end else if ((curState == ST_SETTLE) && (settleCount != '0)) begin
      settleCount <= settleCount - 1'b1;
    end
  end

  // Scoring lands one edge after the sampled cycle; both counters stick at their maximum.
  always_ff @(posedge clock) begin
    if (clear) begin
      mismatch      <= 1'b0;
      err_count     <= '0;
      checked_count <= '0;
    end else begin
      mismatch <= miss;
      if (doCompare && (checked_count != CHK_MAX)) begin
        checked_count <= checked_count + 1'b1;
      end
      if (miss && (err_count != ERR_MAX)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dff_response_checker.sv
// Directed bench for dff_response_checker: default, stop-on-fail and narrow-error-counter instances.
module tb_dff_response_checker;

  logic clock = 1'b0;
  logic stimD = 1'b0;
  logic stimClr = 1'b0;
  logic refQ = 1'b0;
  logic good;

  logic clrA = 1'b1, enA = 1'b0, flipA = 1'b0, qA;
  logic clrC = 1'b1, enB = 1'b0, flipB = 1'b0, qB;
  logic enC = 1'b0, flipC = 1'b0, qC;

  logic expA, misA, passA;
  logic [7:0] errA;
  logic [15:0] chkA;
  logic [1:0] stA;

  logic expB, misB, passB;
  logic [7:0] errB;
  logic [15:0] chkB;
  logic [1:0] stB;

  logic expC, misC, passC;
  logic [1:0] errC;
  logic [15:0] chkC;
  logic [1:0] stC;

  int checkCount = 0;
  int passCount = 0;

  always #5 clock = ~clock;

  // Behaviour of a correct DFF with asynchronous clear, used as the DUT output.
  always @(posedge clock) refQ <= stimClr ? 1'b0 : stimD;
  assign good = stimClr ? 1'b0 : refQ;
  assign qA = good ^ flipA;
  assign qB = good ^ flipB;
  assign qC = good ^ flipC;

  dff_response_checker dutA (
    .clock(clock), .clear(clrA), .enable(enA), .stim_d(stimD), .stim_clr(stimClr),
    .dut_q(qA), .expected(expA), .mismatch(misA), .err_count(errA),
    .checked_count(chkA), .state(stA), .pass(passA)
  );

  dff_response_checker #(.STOP_ON_FAIL(1)) dutB (
    .clock(clock), .clear(clrA), .enable(enB), .stim_d(stimD), .stim_clr(stimClr),
    .dut_q(qB), .expected(expB), .mismatch(misB), .err_count(errB),
    .checked_count(chkB), .state(stB), .pass(passB)
  );

  dff_response_checker #(.ERR_W(2)) dutC (
    .clock(clock), .clear(clrC), .enable(enC), .stim_d(stimD), .stim_clr(stimClr),
    .dut_q(qC), .expected(expC), .mismatch(misC), .err_count(errC),
    .checked_count(chkC), .state(stC), .pass(passC)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checkCount++; if (stA !== 2'd0) $display("[TB] FAIL reset_state got %0d want 0", stA); else passCount++;
    checkCount++; if (errA !== 8'd0) $display("[TB] FAIL reset_err got %0d want 0", errA); else passCount++;
    checkCount++; if (chkA !== 16'd0) $display("[TB] FAIL reset_chk got %0d want 0", chkA); else passCount++;
    checkCount++; if (misA !== 1'b0) $display("[TB] FAIL reset_mis got %b want 0", misA); else passCount++;
    checkCount++; if (passA !== 1'b0) $display("[TB] FAIL reset_pass got %b want 0", passA); else passCount++;
    clrA = 1'b0;
    clrC = 1'b0;
  endtask

  task automatic test_settle();
    enA = 1'b1;
    tick();
    checkCount++; if (stA !== 2'd1) $display("[TB] FAIL settle_enter got %0d want 1", stA); else passCount++;
    tick();
    checkCount++; if (stA !== 2'd1) $display("[TB] FAIL settle_hold got %0d want 1", stA); else passCount++;
    tick();
    checkCount++; if (stA !== 2'd2) $display("[TB] FAIL settle_check got %0d want 2", stA); else passCount++;
    checkCount++; if (chkA !== 16'd0) $display("[TB] FAIL settle_nocmp got %0d want 0", chkA); else passCount++;
    for (int i = 0; i < 18; i++) begin
      stimD = ((i / 2) % 2) == 0;
      tick();
    end
    checkCount++; if (chkA !== 16'd18) $display("[TB] FAIL run_chk got %0d want 18", chkA); else passCount++;
    checkCount++; if (errA !== 8'd0) $display("[TB] FAIL run_err got %0d want 0", errA); else passCount++;
    checkCount++; if (passA !== 1'b1) $display("[TB] FAIL run_pass got %b want 1", passA); else passCount++;
  endtask

  task automatic test_clear();
    stimD = 1'b1;
    stimClr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkCount++; if (expA !== 1'b0) $display("[TB] FAIL clr_expect[%0d] got %b want 0", i, expA); else passCount++;
    end
    stimClr = 1'b0;
    #1;
    checkCount++; if (expA !== 1'b0) $display("[TB] FAIL clr_release got %b want 0", expA); else passCount++;
    tick();
    checkCount++; if (expA !== 1'b1) $display("[TB] FAIL clr_after got %b want 1", expA); else passCount++;
    checkCount++; if (errA !== 8'd0) $display("[TB] FAIL clr_err got %0d want 0", errA); else passCount++;
    checkCount++; if (chkA !== 16'd23) $display("[TB] FAIL clr_chk got %0d want 23", chkA); else passCount++;
  endtask

  task automatic test_inject();
    flipA = 1'b1;
    #1;
    checkCount++; if (misA !== 1'b0) $display("[TB] FAIL inj_pre got %b want 0", misA); else passCount++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkCount++; if (misA !== 1'b1) $display("[TB] FAIL inj_pulse[%0d] got %b want 1", i, misA); else passCount++;
    end
    flipA = 1'b0;
    tick();
    checkCount++; if (misA !== 1'b0) $display("[TB] FAIL inj_end got %b want 0", misA); else passCount++;
    checkCount++; if (errA !== 8'd3) $display("[TB] FAIL inj_err got %0d want 3", errA); else passCount++;
    checkCount++; if (passA !== 1'b0) $display("[TB] FAIL inj_pass got %b want 0", passA); else passCount++;
    checkCount++; if (stA !== 2'd2) $display("[TB] FAIL inj_state got %0d want 2", stA); else passCount++;
  endtask

  task automatic test_back_to_back();
    flipA = 1'b1;
    enA = 1'b0;
    tick();
    checkCount++; if (misA !== 1'b1) $display("[TB] FAIL b2b_mis got %b want 1", misA); else passCount++;
    checkCount++; if (errA !== 8'd4) $display("[TB] FAIL b2b_err got %0d want 4", errA); else passCount++;
    checkCount++; if (stA !== 2'd0) $display("[TB] FAIL b2b_state got %0d want 0", stA); else passCount++;
    flipA = 1'b0;
    tick();
    checkCount++; if (misA !== 1'b0) $display("[TB] FAIL b2b_idle_mis got %b want 0", misA); else passCount++;
    checkCount++; if (errA !== 8'd4) $display("[TB] FAIL b2b_keep got %0d want 4", errA); else passCount++;
  endtask

  task automatic test_stop_on_fail();
    enB = 1'b1;
    repeat (3) tick();
    checkCount++; if (stB !== 2'd2) $display("[TB] FAIL stop_check got %0d want 2", stB); else passCount++;
    repeat (2) tick();
    checkCount++; if (chkB !== 16'd2) $display("[TB] FAIL stop_prechk got %0d want 2", chkB); else passCount++;
    flipB = 1'b1;
    tick();
    checkCount++; if (stB !== 2'd3) $display("[TB] FAIL stop_halt got %0d want 3", stB); else passCount++;
    checkCount++; if (errB !== 8'd1) $display("[TB] FAIL stop_err got %0d want 1", errB); else passCount++;
    checkCount++; if (misB !== 1'b1) $display("[TB] FAIL stop_mis got %b want 1", misB); else passCount++;
    checkCount++; if (chkB !== 16'd3) $display("[TB] FAIL stop_chk got %0d want 3", chkB); else passCount++;
    flipB = 1'b0;
    tick();
    checkCount++; if (chkB !== 16'd3) $display("[TB] FAIL stop_frozen got %0d want 3", chkB); else passCount++;
    checkCount++; if (misB !== 1'b0) $display("[TB] FAIL stop_halt_mis got %b want 0", misB); else passCount++;
    checkCount++; if (stB !== 2'd3) $display("[TB] FAIL stop_stay got %0d want 3", stB); else passCount++;
    checkCount++; if (passB !== 1'b0) $display("[TB] FAIL stop_pass got %b want 0", passB); else passCount++;
  endtask

  task automatic test_saturate();
    enC = 1'b1;
    repeat (3) tick();
    checkCount++; if (stC !== 2'd2) $display("[TB] FAIL sat_check got %0d want 2", stC); else passCount++;
    flipC = 1'b1;
    repeat (3) tick();
    checkCount++; if (errC !== 2'd3) $display("[TB] FAIL sat_err got %0d want 3", errC); else passCount++;
    checkCount++; if (stC !== 2'd3) $display("[TB] FAIL sat_halt got %0d want 3", stC); else passCount++;
    repeat (2) tick();
    checkCount++; if (errC !== 2'd3) $display("[TB] FAIL sat_hold got %0d want 3", errC); else passCount++;
    checkCount++; if (chkC !== 16'd3) $display("[TB] FAIL sat_chk got %0d want 3", chkC); else passCount++;
    enC = 1'b0;
    tick();
    checkCount++; if (stC !== 2'd0) $display("[TB] FAIL sat_idle got %0d want 0", stC); else passCount++;
    checkCount++; if (errC !== 2'd3) $display("[TB] FAIL sat_keep got %0d want 3", errC); else passCount++;
    clrC = 1'b1;
    tick();
    checkCount++; if (errC !== 2'd0) $display("[TB] FAIL sat_clr_err got %0d want 0", errC); else passCount++;
    checkCount++; if (chkC !== 16'd0) $display("[TB] FAIL sat_clr_chk got %0d want 0", chkC); else passCount++;
    clrC = 1'b0;
    flipC = 1'b0;
  endtask

  initial begin
    test_reset();
    test_settle();
    test_clear();
    test_inject();
    test_back_to_back();
    test_stop_on_fail();
    test_saturate();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
